qpsk_sym_gen: RTL and testbench
===============================

Name: qpsk_sym_gen

Overview:
- Upstream symbol source for the QPSK modulator; runs in the 120 MHz modulator clock domain, replacing the separate-clock base generator.
- Derives the symbol-rate strobe internally and emits framed dibits: fixed preamble, PRBS15 payload, then an idle gap.
- The modulator samples sym_data on each sym_valid pulse.

Parameters:
- SYM_DIV, 1200: clk cycles per symbol (120 MHz / 1200 = 100 ksym/s); legal range ≥ 2.
- PRE_LEN, 16: preamble length in symbols; legal range 1..16.
- PRE_PAT, 32'h1ACF_FC1D: preamble bit pattern, MSB first, 2 bits per symbol.
- PAY_LEN, 240: payload symbols per frame; legal range ≥ 1.
- GAP_LEN, 8: idle symbols (2'b00) after each payload; 0 allowed.
- PRBS_SEED, 15'h7FFF: LFSR reset/frame-start value; must be non-zero.

Ports:
- clk  in  1  modulator clock (120 MHz)
- rst  in  1  reset; synchronous, active-high
- en  in  1  level; start/continue framing
- sym_data  out  2  current dibit; held between strobes
- sym_valid  out  1  one-cycle strobe per new symbol
- frame_start  out  1  coincides with sym_valid on the first preamble symbol
- busy  out  1  high in any state other than IDLE
- sym_idx  out  8  index of the current symbol within its phase; 0-based

Behaviour:
- Reset: all outputs 0; state IDLE; LFSR = PRBS_SEED; tick counter = 0; diff accumulator = 0.
- Tick counter:
  - Free-runs 0..SYM_DIV-1 at all times except during reset.
  - tick = (cnt == SYM_DIV-1); the counter then wraps to 0.
  - A symbol can only be issued on a tick cycle.
- FSM (advances only on tick):
  - IDLE: if en=1 on a tick, load symbol 0 of PRE; go to PRE.
  - PRE: issue PRE_PAT bits [31-2k : 30-2k] for k = 0..PRE_LEN-1. After the last one, the next tick issues payload symbol 0 and the state goes to PAY.
  - PAY: each symbol = two LFSR output bits, first bit to sym_data[1]. After PAY_LEN symbols, go to GAP, or to PRE if GAP_LEN = 0.
  - GAP: issue 2'b00 for GAP_LEN symbols. Then:
    - en=1: go to PRE with a new frame; frame_start pulses.
    - en=0: go to IDLE with no symbol issued.
- Output timing:
  - On every issuing tick, the registered outputs update on the following edge. Latency is 1 clk from tick.
  - sym_valid is high for exactly 1 cycle per symbol.
  - sym_data and sym_idx hold until the next issue.
- LFSR:
  - Fibonacci x^15+x^14+1.
  - Output bit = s[14]; new s[0] = s[14]^s[13]; shift left one step per bit, two steps per payload symbol.
  - Re-seeded to PRBS_SEED on each frame_start, so every frame's payload is identical.
- en deassert mid-frame: the current frame completes, including GAP; then the block returns to IDLE. en re-asserted before the GAP ends continues seamlessly.
- en pulse shorter than SYM_DIV between ticks is not guaranteed to start a frame; en is level-sampled on tick only.
- rst mid-frame: immediate return to reset values on the next edge; the counter restarts from 0.
- sym_idx: resets to 0 at each phase transition and increments per symbol. Width 8 is sufficient for defaults; larger PAY_LEN wraps modulo 256, which is accepted.

Optional Feature:
- Macro: QPSK_DIFF_ENC_EN.
- Defined:
  - Issued symbol = (acc + raw) mod 4, where raw is the PRE/PAY/GAP dibit; acc then takes this value.
  - acc clears to 0 on reset and on each frame_start.
  - Rotation: 00 = 0°, 01 = +90°, 10 = +180°, 11 = +270°.
  - Gives differential QPSK for phase-ambiguous receivers.
- Undefined: raw dibits are issued directly; the acc register is absent.

Decomposition:
- Package qpsk_pkg:
  - State enum (IDLE, PRE, PAY, GAP).
  - Symbol type (2-bit).
  - PRBS15 tap constants.
  - Default PRE_PAT.
- Sub-module prbs15_lfsr, interface:
  - Inputs: clk, rst, load, seed, step2.
  - Output: dibit.
  - Generic enough to reuse in a future demodulator BER checker.

Test Plan:
- Reset: hold rst 3 cycles with en=1 → all outputs 0; release; first sym_valid arrives 1200 cycles later with frame_start=1, sym_data=2'b00.
- Preamble (defaults): first 4 symbols = 00, 01, 10, 10. sym_valid spacing is exactly 1200 cycles. busy=1.
- Payload (seed 7FFF): payload symbols 0..6 are all 2'b11. Check 240 payload symbols against a reference PRBS15 model, then 8 symbols of 2'b00.
- en dropped during payload symbol 100 → frame completes through GAP; busy falls; no further sym_valid for 10 symbol periods. Re-raise en → new frame_start; payload repeats bit-exact.
- rst mid-preamble (symbol 5) → outputs 0 next edge; frame restarts from preamble symbol 0 once rst falls and the next tick occurs.
- With QPSK_DIFF_ENC_EN: preamble 00, 01, 10, 10 → issued 00, 01, 11, 01. Without the macro: identical to raw.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK symbol source.
// Used by qpsk_sym_gen and prbs15_lfsr.
package qpsk_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_PAY, ST_GAP} state_e;
    typedef logic [1:0] sym_t;

    // PRBS15, x^15 + x^14 + 1: taps at state bits 14 and 13
    localparam int          PRBS_W        = 15;
    localparam int          PRBS_TAP_A    = 14;
    localparam int          PRBS_TAP_B    = 13;
    localparam logic [14:0] PRBS_SEED_DEF = 15'h7FFF;

    localparam logic [31:0] PRE_PAT_DEF   = 32'h1ACF_FC1D;

    // Dibit k of a 32-bit pattern, MSB first
    function automatic sym_t pre_sym(input logic [31:0] pat, input logic [3:0] k);
        logic [4:0] sh;
        sh = 5'd30 - {k, 1'b0};
        return sym_t'(pat >> sh);
    endfunction

endpackage

// File: rtl/prbs15_lfsr.sv
// Fibonacci PRBS15 generator stepping two bits per request; dibit_o shows
// the next two output bits (first bit in dibit_o[1]).
module prbs15_lfsr
    import qpsk_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [14:0] seed_i,
    input  logic        step2_i,
    output logic [1:0]  dibit_o
);

    logic [PRBS_W-1:0] s_q, s_d, s1;

    assign s1 = {s_q[PRBS_W-2:0], s_q[PRBS_TAP_A] ^ s_q[PRBS_TAP_B]};

    always_comb begin
        s_d = s_q;
        if (load_i)
            s_d = seed_i;
        else if (step2_i)
            s_d = {s1[PRBS_W-2:0], s1[PRBS_TAP_A] ^ s1[PRBS_TAP_B]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) s_q <= seed_i;
        else       s_q <= s_d;
    end

    // After one shift, the new s[14] is the old s[13]
    assign dibit_o = {s_q[PRBS_TAP_A], s_q[PRBS_TAP_B]};

endmodule

// File: rtl/qpsk_sym_gen.sv
// Framed QPSK dibit source: preamble, PRBS15 payload, idle gap, paced by an
// internal symbol strobe. Define QPSK_DIFF_ENC_EN for differential encoding.
module qpsk_sym_gen
    import qpsk_pkg::*;
#(
    parameter int unsigned SYM_DIV   = 1200,
    parameter int unsigned PRE_LEN   = 16,
    parameter logic [31:0] PRE_PAT   = PRE_PAT_DEF,
    parameter int unsigned PAY_LEN   = 240,
    parameter int unsigned GAP_LEN   = 8,
    parameter logic [14:0] PRBS_SEED = PRBS_SEED_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic [1:0] sym_data_o,
    output logic       sym_valid_o,
    output logic       frame_start_o,
    output logic       busy_o,
    output logic [7:0] sym_idx_o
);

    localparam int CNT_W = $clog2(SYM_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic             tick;

    assign tick = (cnt_q == CNT_W'(SYM_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i)     cnt_q <= '0;
        else if (tick) cnt_q <= '0;
        else           cnt_q <= cnt_q + 1'b1;
    end

    state_e      state_q, state_d;
    logic [15:0] ph_q, ph_d;
    sym_t        data_q, data_d, raw, enc, lfsr_dibit;
    logic        valid_q, fs_q, fs_d;
    logic        issue, frame_end, lfsr_load, lfsr_step;

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        raw       = 2'b00;
        issue     = 1'b0;
        fs_d      = 1'b0;
        frame_end = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: frame_end = 1'b1;
                ST_PRE: begin
                    issue = 1'b1;
                    if (ph_q == 16'(PRE_LEN - 1)) begin
                        state_d   = ST_PAY;
                        ph_d      = '0;
                        raw       = lfsr_dibit;
                        lfsr_step = 1'b1;
                    end else begin
                        ph_d = ph_q + 16'd1;
                        raw  = pre_sym(PRE_PAT, ph_q[3:0] + 4'd1);
                    end
                end
                ST_PAY: begin
                    if (ph_q == 16'(PAY_LEN - 1)) begin
                        if (GAP_LEN != 0) begin
                            state_d = ST_GAP;
                            ph_d    = '0;
                            issue   = 1'b1;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end else begin
                        ph_d      = ph_q + 16'd1;
                        issue     = 1'b1;
                        raw       = lfsr_dibit;
                        lfsr_step = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (ph_q == 16'(GAP_LEN - 1)) begin
                        frame_end = 1'b1;
                    end else begin
                        ph_d  = ph_q + 16'd1;
                        issue = 1'b1;
                    end
                end
            endcase
        end
        // Frame boundary: start a new frame if enabled, otherwise park in IDLE
        // leaving the last symbol and index on the outputs.
        if (frame_end) begin
            if (en_i) begin
                state_d   = ST_PRE;
                ph_d      = '0;
                issue     = 1'b1;
                raw       = pre_sym(PRE_PAT, 4'd0);
                fs_d      = 1'b1;
                lfsr_load = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

`ifdef QPSK_DIFF_ENC_EN
    sym_t acc_q;

    // Accumulated phase restarts from 0 at every frame start
    assign enc = (fs_d ? 2'b00 : acc_q) + raw;

    always_ff @(posedge clk_i) begin
        if (rst_i)      acc_q <= 2'b00;
        else if (issue) acc_q <= enc;
    end
`else
    assign enc = raw;
`endif

    assign data_d = issue ? enc : data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            data_q  <= 2'b00;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            data_q  <= data_d;
            valid_q <= issue;
            fs_q    <= fs_d;
        end
    end

    prbs15_lfsr u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (lfsr_load),
        .seed_i  (PRBS_SEED),
        .step2_i (lfsr_step),
        .dibit_o (lfsr_dibit)
    );

    assign sym_data_o    = data_q;
    assign sym_valid_o   = valid_q;
    assign frame_start_o = fs_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign sym_idx_o     = ph_q[7:0];

endmodule

// File: tb/tb_qpsk_sym_gen.sv
// Directed bench: a default-rate instance for reset/latency/spacing and a
// fast-strobe instance for full frames, en drop, idle and mid-frame reset.
module tb_qpsk_sym_gen;

    localparam int FD    = 4;
    localparam int PRE_N = 16;
    localparam int PAY_N = 240;
    localparam int GAP_N = 8;
    localparam int FR_N  = PRE_N + PAY_N + GAP_N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, va, fa, ba;
    logic [1:0] da;
    logic [7:0] ia;
    logic       rst_b, en_b, vb, fb, bb;
    logic [1:0] db;
    logic [7:0] ib;

    qpsk_sym_gen u_dut (
        .clk_i(clk), .rst_i(rst_a), .en_i(en_a), .sym_data_o(da), .sym_valid_o(va),
        .frame_start_o(fa), .busy_o(ba), .sym_idx_o(ia)
    );

    qpsk_sym_gen #(.SYM_DIV(FD)) u_fast (
        .clk_i(clk), .rst_i(rst_b), .en_i(en_b), .sym_data_o(db), .sym_valid_o(vb),
        .frame_start_o(fb), .busy_o(bb), .sym_idx_o(ib)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Expected issued symbol for each position of a frame
    logic [1:0] fr [FR_N];

    task automatic build_model;
        logic [31:0] pat  = 32'h1ACF_FC1D;
        logic [14:0] seed = 15'h7FFF;
        logic        b [2*PAY_N];
        logic [1:0]  acc  = 2'b00;
        // PRBS output stream: b[n+15] = b[n] ^ b[n+1]
        for (int i = 0; i < 15; i++) b[i] = seed[14-i];
        for (int i = 15; i < 2*PAY_N; i++) b[i] = b[i-15] ^ b[i-14];
        for (int k = 0; k < PRE_N; k++) fr[k] = {pat[31-2*k], pat[30-2*k]};
        for (int k = 0; k < PAY_N; k++) fr[PRE_N+k] = {b[2*k], b[2*k+1]};
        for (int k = 0; k < GAP_N; k++) fr[PRE_N+PAY_N+k] = 2'b00;
`ifdef QPSK_DIFF_ENC_EN
        for (int i = 0; i < FR_N; i++) begin
            acc   = acc + fr[i];
            fr[i] = acc;
        end
`else
        acc = 2'b00;
`endif
    endtask

    function automatic int exp_idx(input int i);
        if (i < PRE_N)         return i;
        if (i < PRE_N + PAY_N) return i - PRE_N;
        return i - PRE_N - PAY_N;
    endfunction

    task automatic get_a(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!va && n < 1300);
        if (!va) chk("a_timeout", n, -1);
    endtask

    task automatic get_b(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!vb && n < 4*FD);
        if (!vb) chk("b_timeout", n, -1);
    endtask

    task automatic run_frame(input int drop_at, input bit chk_first);
        int n;
        for (int i = 0; i < FR_N; i++) begin
            get_b(n);
            if (i > 0 || chk_first) chk($sformatf("b_space[%0d]", i), n, FD);
            chk($sformatf("b_data[%0d]", i), db, fr[i]);
            chk($sformatf("b_fs[%0d]", i), fb, (i == 0) ? 1 : 0);
            chk($sformatf("b_idx[%0d]", i), ib, exp_idx(i));
            chk($sformatf("b_busy[%0d]", i), bb, 1);
`ifndef QPSK_DIFF_ENC_EN
            if (i >= PRE_N && i < PRE_N + 7) chk($sformatf("b_pay11[%0d]", i), db, 3);
`endif
            if (i == drop_at) en_b = 1'b0;
        end
    endtask

    initial begin
        int n, nv;
        rst_a = 1'b1; en_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b0;
        build_model();
        repeat (3) @(negedge clk);
        chk("a_rst", {da, va, fa, ba, ia}, 0);
        chk("b_rst", {db, vb, fb, bb, ib}, 0);

        // Default rate: first symbol 1200 cycles after release, then 1200 apart
        rst_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            get_a(n);
            chk($sformatf("a_space[%0d]", k), n, 1200);
            chk($sformatf("a_data[%0d]", k), da, fr[k]);
            chk($sformatf("a_fs[%0d]", k), fa, (k == 0) ? 1 : 0);
            chk($sformatf("a_idx[%0d]", k), ia, k);
            chk($sformatf("a_busy[%0d]", k), ba, 1);
        end
        rst_a = 1'b1;

        // Fast instance: two back-to-back frames, en dropped in payload symbol 100
        rst_b = 1'b0; en_b = 1'b1;
        run_frame(-1, 1'b1);
        run_frame(PRE_N + 100, 1'b1);

        nv = 0;
        repeat (FD + 10*FD) begin
            @(negedge clk);
            if (vb) nv++;
        end
        chk("b_idle_valid", nv, 0);
        chk("b_idle_busy", bb, 0);
        chk("b_idle_hold", db, fr[FR_N-1]);

        en_b = 1'b1;
        run_frame(-1, 1'b0);

        // Seamless next frame, reset during preamble symbol 5
        for (int i = 0; i < 6; i++) begin
            get_b(n);
            chk($sformatf("b_pre4[%0d]", i), db, fr[i]);
        end
        rst_b = 1'b1;
        @(negedge clk);
        chk("b_mid_rst", {db, vb, fb, bb, ib}, 0);
        rst_b = 1'b0;
        get_b(n);
        chk("b_rst_lat", n, FD);
        chk("b_rst_data", db, fr[0]);
        chk("b_rst_fs", fb, 1);
        chk("b_rst_idx", ib, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
